// File: rtl/mem_line_ctrl.sv
// -----------------------------------------------------------------------------
// mem_line_ctrl
// Multi-channel, cache-line-wide main-memory model and controller for brisc.
// Requests from NUM_CH channels are arbitrated round-robin and strictly
// serialised. Each accepted request spends REQ_DELAY cycles in the request
// phase, one ACCESS cycle on the array, RESP_DELAY cycles in the response
// phase and one DONE cycle that pulses resp_valid for the owning channel.
//
// Optional feature macro: MEM_LINE_CTRL_BYTE_WE_EN
//   defined   -> adds req_wstrb; writes update only strobed bytes
//   undefined -> every write replaces the full line
//
// Ports
//   clk         in  1                 rising-edge clock
//   rst_n       in  1                 asynchronous active-low reset
//   req_valid   in  NUM_CH            per-channel request valid
//   req_ready   out NUM_CH            per-channel accept (one-hot or zero)
//   req_we      in  NUM_CH            1 = write, 0 = read
//   req_addr    in  NUM_CH*ADDR_W     packed byte addresses
//   req_wdata   in  NUM_CH*LINE_W     packed write lines
//   req_wstrb   in  NUM_CH*LINE_W/8   packed byte strobes (macro only)
//   resp_valid  out NUM_CH            one-cycle completion pulse
//   resp_rdata  out LINE_W            last line read from the array
//   busy        out 1                 request in flight
// -----------------------------------------------------------------------------
module mem_line_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int DEPTH      = 1024,
  parameter int REQ_DELAY  = 5,
  parameter int RESP_DELAY = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*LINE_W-1:0]   req_wdata,
`ifdef MEM_LINE_CTRL_BYTE_WE_EN
  input  logic [NUM_CH*(LINE_W/8)-1:0] req_wstrb,
`endif
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [LINE_W-1:0]          resp_rdata,
  output logic                       busy
);

  localparam int BYTES   = LINE_W / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_DELAY - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_DELAY - 1);
  localparam logic [CH_W-1:0]  PTR_RST   = CH_W'(NUM_CH - 1);

  // Parameter sanity: refuse to elaborate a meaningless configuration.
  generate
    if (REQ_DELAY < 1) begin : g_bad_req_delay
      $error("mem_line_ctrl: REQ_DELAY must be >= 1");
    end
    if (RESP_DELAY < 1) begin : g_bad_resp_delay
      $error("mem_line_ctrl: RESP_DELAY must be >= 1");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
      $error("mem_line_ctrl: NUM_CH must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [CH_W-1:0]    ptr_r;
  logic [CH_W-1:0]    gnt_idx_s;
  logic               gnt_found_s;
  logic               accept_s;

  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [LINE_W-1:0]  sel_wdata_s;

  logic [CH_W-1:0]    lat_ch_r;
  logic               lat_we_r;
  logic [IDX_W-1:0]   lat_idx_r;
  logic [LINE_W-1:0]  lat_wdata_r;
  logic [NUM_CH-1:0]  lat_ch_oh_s;

  logic [LINE_W-1:0]  rdata_r;
  logic [NUM_CH-1:0]  resp_valid_r;
  logic               busy_r;

  logic [LINE_W-1:0]  mem_r [DEPTH];

`ifdef MEM_LINE_CTRL_BYTE_WE_EN
  logic [BYTES-1:0]   sel_wstrb_s;
  logic [BYTES-1:0]   lat_wstrb_r;
`endif

  // Offset bits and address bits above the line index do not select storage.
  logic unused_addr_s;
  assign unused_addr_s = ^req_addr;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int  cand_v;
    logic hit_v;
    cand_v      = 0;
    hit_v       = 1'b0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_v      = (int'(ptr_r) + 1 + k) % NUM_CH;
      hit_v       = !gnt_found_s && req_valid[cand_v];
      gnt_idx_s   = hit_v ? CH_W'(cand_v) : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_v;
    end
  end

  // Ready is offered only in IDLE, and forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_r == ST_IDLE) && gnt_found_s) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s = |(req_valid & req_ready);

  // Payload multiplexer for the granted channel.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
`ifdef MEM_LINE_CTRL_BYTE_WE_EN
    sel_wstrb_s = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      sel_we_s    = (gnt_idx_s == CH_W'(i)) ? req_we[i]                     : sel_we_s;
      sel_addr_s  = (gnt_idx_s == CH_W'(i)) ? req_addr[i*ADDR_W +: ADDR_W]  : sel_addr_s;
      sel_wdata_s = (gnt_idx_s == CH_W'(i)) ? req_wdata[i*LINE_W +: LINE_W] : sel_wdata_s;
`ifdef MEM_LINE_CTRL_BYTE_WE_EN
      sel_wstrb_s = (gnt_idx_s == CH_W'(i)) ? req_wstrb[i*BYTES +: BYTES]   : sel_wstrb_s;
`endif
    end
  end

  // One-hot form of the owning channel for the completion pulse.
  always_comb begin
    lat_ch_oh_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lat_ch_oh_s[i] = (lat_ch_r == CH_W'(i));
    end
  end

  // Next-state and phase-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_REQ;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (cnt_r == REQ_LAST) begin
          state_nxt_s = ST_ACCESS;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_nxt_s = ST_RESP;
        cnt_nxt_s   = '0;
      end
      ST_RESP: begin
        if (cnt_r == RESP_LAST) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request capture and round-robin pointer update at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= PTR_RST;
      lat_ch_r    <= '0;
      lat_we_r    <= 1'b0;
      lat_idx_r   <= '0;
      lat_wdata_r <= '0;
`ifdef MEM_LINE_CTRL_BYTE_WE_EN
      lat_wstrb_r <= '0;
`endif
    end else if (accept_s) begin
      ptr_r       <= gnt_idx_s;
      lat_ch_r    <= gnt_idx_s;
      lat_we_r    <= sel_we_s;
      lat_idx_r   <= sel_addr_s[OFF_W +: IDX_W];
      lat_wdata_r <= sel_wdata_s;
`ifdef MEM_LINE_CTRL_BYTE_WE_EN
      lat_wstrb_r <= sel_wstrb_s;
`endif
    end
  end

  // Array write during ACCESS; storage itself is never reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_ACCESS) && lat_we_r) begin
`ifdef MEM_LINE_CTRL_BYTE_WE_EN
      for (int b = 0; b < BYTES; b++) begin
        if (lat_wstrb_r[b]) begin
          mem_r[lat_idx_r][b*8 +: 8] <= lat_wdata_r[b*8 +: 8];
        end
      end
`else
      mem_r[lat_idx_r] <= lat_wdata_r;
`endif
    end
  end

  // Read capture during ACCESS; holds across writes until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if ((state_r == ST_ACCESS) && !lat_we_r) begin
      rdata_r <= mem_r[lat_idx_r];
    end
  end

  // Completion pulse is registered so it coincides exactly with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= '0;
    end else if (state_nxt_s == ST_DONE) begin
      resp_valid_r <= lat_ch_oh_s;
    end else begin
      resp_valid_r <= '0;
    end
  end

  // Busy spans from the acceptance edge to the edge that ends DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else if (accept_s) begin
      busy_r <= 1'b1;
    end else if (state_r == ST_DONE) begin
      busy_r <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_rdata = rdata_r;
  assign busy       = busy_r;

endmodule
